// File: rtl/star_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : star_anim_ctrl
// Brief    : Draw / hold / erase / step animation controller for a SIZExSIZE
//            star sprite on the VGA plot path. Optional edge reflection is
//            selected with the STAR_BOUNCE_EN macro (wrap-around otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module star_anim_ctrl #(
    parameter int         X_MAX  = 160,
    parameter int         Y_MAX  = 120,
    parameter int         SIZE   = 4,
    parameter int         X0     = 0,
    parameter int         Y0     = 0,
    parameter logic [2:0] COLOUR = 3'b111,
    parameter logic [2:0] BG     = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       doneDelay,
    output logic       goDelay,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam int              c_HB   = $clog2(SIZE);
    localparam int              c_CW   = 2 * c_HB;
    localparam logic [c_CW-1:0] c_LAST = {c_CW{1'b1}};
    localparam logic [7:0]      c_LX   = 8'(X_MAX - SIZE);
    localparam logic [6:0]      c_LY   = 7'(Y_MAX - SIZE);
    localparam logic [7:0]      c_X0   = 8'(X0);
    localparam logic [6:0]      c_Y0   = 7'(Y0);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DRAW       = 3'd1,
        S_WAIT       = 3'd2,
        S_ERASE      = 3'd3,
        S_UPDATE     = 3'd4,
        S_HALT_ERASE = 3'd5
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [7:0]      r_px;
    logic [6:0]      r_py;

    logic [c_CW-1:0] w_cnt_inc;
    logic [7:0]      w_x_pix;
    logic [6:0]      w_y_pix;
    logic [7:0]      w_px_n;
    logic [6:0]      w_py_n;

    // Outputs are registered, so they are loaded with the coordinate of the
    // pixel the counter is about to point at.
    assign w_cnt_inc = r_cnt + c_CW'(1);
    assign w_x_pix   = r_px + 8'(w_cnt_inc[c_HB-1:0]);
    assign w_y_pix   = r_py + 7'(w_cnt_inc[c_CW-1:c_HB]);

`ifdef STAR_BOUNCE_EN
    logic r_dx;
    logic r_dy;
    logic w_dx_n;
    logic w_dy_n;

    always_comb begin
        w_px_n = r_px;
        w_dx_n = r_dx;
        if (r_dx) begin
            if (r_px == c_LX) begin
                w_dx_n = 1'b0;
                w_px_n = c_LX - 8'd1;
            end else begin
                w_px_n = r_px + 8'd1;
            end
        end else if (r_px == 8'd0) begin
            w_dx_n = 1'b1;
            w_px_n = 8'd1;
        end else begin
            w_px_n = r_px - 8'd1;
        end

        w_py_n = r_py;
        w_dy_n = r_dy;
        if (r_dy) begin
            if (r_py == c_LY) begin
                w_dy_n = 1'b0;
                w_py_n = c_LY - 7'd1;
            end else begin
                w_py_n = r_py + 7'd1;
            end
        end else if (r_py == 7'd0) begin
            w_dy_n = 1'b1;
            w_py_n = 7'd1;
        end else begin
            w_py_n = r_py - 7'd1;
        end
    end
`else
    assign w_px_n = (r_px == c_LX) ? 8'd0 : r_px + 8'd1;
    assign w_py_n = (r_py == c_LY) ? 7'd0 : r_py + 7'd1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_px    <= c_X0;
            r_py    <= c_Y0;
`ifdef STAR_BOUNCE_EN
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
`endif
            goDelay <= 1'b0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            x       <= c_X0;
            y       <= c_Y0;
            colour  <= BG;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_DRAW;
                        r_cnt   <= '0;
                        plot    <= 1'b1;
                        busy    <= 1'b1;
                        colour  <= COLOUR;
                        x       <= r_px;
                        y       <= r_py;
                    end
                end

                S_DRAW, S_ERASE, S_HALT_ERASE: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt <= '0;
                        plot  <= 1'b0;
                        x     <= r_px;
                        y     <= r_py;
                        if (r_state == S_DRAW) begin
                            r_state <= S_WAIT;
                            goDelay <= 1'b1;
                        end else if (r_state == S_ERASE) begin
                            r_state <= S_UPDATE;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            colour  <= BG;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        x     <= w_x_pix;
                        y     <= w_y_pix;
                    end
                end

                S_WAIT: begin
                    if (doneDelay) begin
                        r_state <= stop ? S_HALT_ERASE : S_ERASE;
                        r_cnt   <= '0;
                        goDelay <= 1'b0;
                        plot    <= 1'b1;
                        colour  <= BG;
                        x       <= r_px;
                        y       <= r_py;
                    end
                end

                S_UPDATE: begin
                    r_state <= S_DRAW;
                    r_cnt   <= '0;
                    r_px    <= w_px_n;
                    r_py    <= w_py_n;
`ifdef STAR_BOUNCE_EN
                    r_dx    <= w_dx_n;
                    r_dy    <= w_dy_n;
`endif
                    plot    <= 1'b1;
                    colour  <= COLOUR;
                    x       <= w_px_n;
                    y       <= w_py_n;
                end

                default: begin
                    r_state <= S_IDLE;
                    plot    <= 1'b0;
                    goDelay <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
